// File: rtl/sram_responder_pkg.sv
// slc3_mem_pkg: shared types and constants for the SLC-3 SRAM responder
package slc3_mem_pkg;
   localparam int MAX_READ_LAT = 4;
   localparam int DATA_W = 16;
   localparam int BUS_ADDR_W = 20;
   typedef enum logic {INIT, READY} sram_state_t;
   typedef struct packed {
      logic v;
      logic ub;
      logic lb;
      logic [DATA_W-1:0] d;
   } rd_slot_t;
endpackage

// File: rtl/sram_responder_if.sv
// sram_responder_if: active-low SRAM control strobes and word address driven by the CPU memory path
interface sram_responder_if;
   import slc3_mem_pkg::*;
   logic CE, UB, LB, OE, WE;
   logic [BUS_ADDR_W-1:0] ADDR;
   modport master (output CE, UB, LB, OE, WE, ADDR);
   modport slave (input CE, UB, LB, OE, WE, ADDR);
endinterface

// File: rtl/sram_responder_rd_pipe.sv
// sram_rd_pipe: LAT-stage read result shift register, cleared asynchronously on Reset
module sram_rd_pipe
   import slc3_mem_pkg::*;
#(
   parameter int LAT = 1
) (
   input  logic     Clk,
   input  logic     Reset,
   input  rd_slot_t push,
   output rd_slot_t head
);
   rd_slot_t st [LAT];
   always_ff @(posedge Clk or negedge Reset)
      if (!Reset) for (int i = 0; i < LAT; i++) st[i] <= '0;
      else begin
         st[0] <= push;
         for (int i = 1; i < LAT; i++) st[i] <= st[i-1];
      end
   assign head = st[LAT-1];
endmodule

// File: rtl/sram_responder.sv
// sram_responder: memory end of the SLC-3 SRAM bus with byte writes, pipelined reads and a clear sweep
module sram_responder
   import slc3_mem_pkg::*;
#(
   parameter int          ADDR_W   = 10,
   parameter int          READ_LAT = 1,
   parameter logic [15:0] INIT_VAL = 16'h0000
) (
   input  logic                Clk,
   input  logic                Reset,
   sram_responder_if.slave     bus,
   inout  wire  [DATA_W-1:0]   Data,
   output logic                init_done,
   output logic                oob,
   output logic [15:0]         rd_count,
   output logic [15:0]         wr_count
);
   localparam int DEPTH = 2**ADDR_W;
   logic [DATA_W-1:0] mem [DEPTH];
   sram_state_t state, state_d;
   logic [ADDR_W-1:0] ptr, a, mem_a;
   logic [DATA_W-1:0] mem_d;
   logic [1:0] mem_be;
   logic mem_we, in_range, acc, wr, rd, drive;
   rd_slot_t push, head;
   assign a = bus.ADDR[ADDR_W-1:0];
   assign in_range = bus.ADDR[BUS_ADDR_W-1:ADDR_W] == '0;
   // bus is only honoured once the sweep has finished and init_done is visible
   assign acc = init_done && !bus.CE && (!bus.UB || !bus.LB);
   assign wr = acc && !bus.WE;
   assign rd = acc && bus.WE && !bus.OE;
   always_comb begin
      state_d = state;
      mem_we = 1'b0;
      mem_be = 2'b00;
      mem_a = ptr;
      mem_d = INIT_VAL;
      if (state == INIT) begin
         mem_we = 1'b1;
         mem_be = 2'b11;
         state_d = ptr == ADDR_W'(DEPTH-1) ? READY : INIT;
      end else if (wr && in_range) begin
         mem_we = 1'b1;
         mem_be = {!bus.UB, !bus.LB};
         mem_a = a;
         mem_d = Data;
      end
   end
   always_ff @(posedge Clk or negedge Reset)
      if (!Reset) begin
         state <= INIT;
         ptr <= '0;
         init_done <= 1'b0;
         oob <= 1'b0;
         rd_count <= '0;
         wr_count <= '0;
      end else begin
         state <= state_d;
         ptr <= state == INIT ? ptr + ADDR_W'(1) : ptr;
         init_done <= state == READY;
         oob <= acc && !in_range;
         rd_count <= rd_count + 16'(rd);
         wr_count <= wr_count + 16'(wr);
      end
   always_ff @(posedge Clk) begin
      if (mem_we && mem_be[1]) mem[mem_a][15:8] <= mem_d[15:8];
      if (mem_we && mem_be[0]) mem[mem_a][7:0] <= mem_d[7:0];
   end
   assign push = '{v: rd, ub: bus.UB, lb: bus.LB, d: in_range ? mem[a] : '0};
   sram_rd_pipe #(.LAT(READ_LAT)) u_pipe (
      .Clk  (Clk),
      .Reset(Reset),
      .push (push),
      .head (head)
   );
   // the master dropping OE or raising a write cancels the drive in the same cycle
   assign drive = head.v && !bus.CE && !bus.OE && bus.WE;
   assign Data[15:8] = drive && !head.ub ? head.d[15:8] : 8'hzz;
   assign Data[7:0] = drive && !head.lb ? head.d[7:0] : 8'hzz;
endmodule

// File: tb/tb_sram_responder.sv
// tb_sram_responder: directed checks of sweep, byte writes, pipelined reads, oob and reset
module tb_sram_responder;
   logic Clk = 1'b0;
   logic Reset = 1'b0;
   logic init_done, oob;
   logic [15:0] rd_count, wr_count;
   logic [15:0] tb_d = '0;
   logic tb_drv = 1'b0;
   wire [15:0] data;
   int n_chk = 0;
   int n_fail = 0;
   int cnt;
   logic z_bad;
   always #5 Clk = ~Clk;
   sram_responder_if bus ();
   assign data = tb_drv ? tb_d : 16'hzzzz;
   // undriven bits read back as 1 so a released bus is observable
   for (genvar g = 0; g < 16; g++) begin : g_pu
      pullup (data[g]);
   end
   sram_responder #(.ADDR_W(6), .READ_LAT(2), .INIT_VAL(16'hC3C3)) dut (
      .Clk      (Clk),
      .Reset    (Reset),
      .bus      (bus),
      .Data     (data),
      .init_done(init_done),
      .oob      (oob),
      .rd_count (rd_count),
      .wr_count (wr_count)
   );
   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask
   task automatic tick();
      @(posedge Clk);
      #1;
   endtask
   task automatic idle();
      bus.CE = 1'b1; bus.UB = 1'b1; bus.LB = 1'b1; bus.OE = 1'b1; bus.WE = 1'b1;
      bus.ADDR = '0;
      tb_drv = 1'b0;
   endtask
   task automatic wr_word(input logic [19:0] a, input logic [15:0] d, input logic ub, input logic lb);
      bus.CE = 1'b0; bus.WE = 1'b0; bus.OE = 1'b1; bus.UB = ub; bus.LB = lb; bus.ADDR = a;
      tb_d = d; tb_drv = 1'b1;
      tick();
      idle();
   endtask
   task automatic rd_word(input string tag, input logic [19:0] a, input logic ub, input logic lb,
                          input logic [15:0] exp);
      bus.CE = 1'b0; bus.WE = 1'b1; bus.OE = 1'b0; bus.UB = ub; bus.LB = lb; bus.ADDR = a;
      tick();
      bus.UB = 1'b1; bus.LB = 1'b1;
      tick();
      chk(tag, data, exp);
      idle();
   endtask
   initial begin
      idle();
      repeat (3) tick();
      chk("reset_data_z", data, 16'hFFFF);
      chk("reset_init_done", 16'(init_done), 16'h0);
      chk("reset_oob", 16'(oob), 16'h0);
      chk("reset_rd_count", rd_count, 16'h0);
      chk("reset_wr_count", wr_count, 16'h0);
      Reset = 1'b1;
      cnt = 0;
      z_bad = 1'b0;
      while (!init_done && cnt < 200) begin
         tick();
         cnt++;
         if (data !== 16'hFFFF) z_bad = 1'b1;
      end
      chk("sweep_edges", 16'(cnt), 16'd65);
      chk("sweep_data_z", 16'(z_bad), 16'h0);
      wr_word(20'h00012, 16'hBEEF, 1'b0, 1'b0);
      chk("wr_count_1", wr_count, 16'd1);
      bus.CE = 1'b0; bus.WE = 1'b1; bus.OE = 1'b0; bus.UB = 1'b0; bus.LB = 1'b0; bus.ADDR = 20'h00012;
      tick();
      bus.UB = 1'b1; bus.LB = 1'b1;
      chk("lat_not_yet", data, 16'hFFFF);
      tick();
      chk("read_beef", data, 16'hBEEF);
      idle();
      chk("rd_count_1", rd_count, 16'd1);
      wr_word(20'h5, 16'h1234, 1'b0, 1'b0);
      wr_word(20'h5, 16'hAB00, 1'b0, 1'b1);
      rd_word("byte_merge", 20'h5, 1'b0, 1'b0, 16'hAB34);
      rd_word("low_byte_only", 20'h5, 1'b1, 1'b0, 16'hFF34);
      wr_word(20'h1, 16'h1111, 1'b0, 1'b0);
      wr_word(20'h2, 16'h2222, 1'b0, 1'b0);
      wr_word(20'h3, 16'h3333, 1'b0, 1'b0);
      bus.CE = 1'b0; bus.WE = 1'b1; bus.OE = 1'b0; bus.UB = 1'b0; bus.LB = 1'b0; bus.ADDR = 20'h1;
      tick();
      bus.ADDR = 20'h2;
      tick();
      chk("stream_1", data, 16'h1111);
      bus.ADDR = 20'h3;
      tick();
      chk("stream_2", data, 16'h2222);
      bus.UB = 1'b1; bus.LB = 1'b1;
      tick();
      chk("stream_3", data, 16'h3333);
      idle();
      chk("rd_count_6", rd_count, 16'd6);
      rd_word("sweep_value", 20'h7, 1'b0, 1'b0, 16'hC3C3);
      bus.CE = 1'b0; bus.WE = 1'b1; bus.OE = 1'b0; bus.UB = 1'b0; bus.LB = 1'b0; bus.ADDR = 20'h5;
      tick();
      bus.UB = 1'b1; bus.LB = 1'b1; bus.OE = 1'b1;
      tick();
      chk("oe_release_z", data, 16'hFFFF);
      idle();
      bus.CE = 1'b0; bus.WE = 1'b1; bus.OE = 1'b0; bus.UB = 1'b0; bus.LB = 1'b0; bus.ADDR = 20'h1;
      tick();
      bus.WE = 1'b0; bus.ADDR = 20'h9;
      tick();
      chk("we_blocks_drive", data, 16'hFFFF);
      idle();
      chk("wr_count_7", wr_count, 16'd7);
      bus.CE = 1'b0; bus.WE = 1'b0; bus.OE = 1'b0; bus.UB = 1'b0; bus.LB = 1'b0; bus.ADDR = 20'h9;
      tb_d = 16'h9A9A; tb_drv = 1'b1;
      tick();
      idle();
      chk("we_wins_rd_count", rd_count, 16'd9);
      chk("we_wins_wr_count", wr_count, 16'd8);
      rd_word("we_wins_data", 20'h9, 1'b0, 1'b0, 16'h9A9A);
      bus.CE = 1'b0; bus.WE = 1'b1; bus.OE = 1'b0; bus.UB = 1'b0; bus.LB = 1'b0; bus.ADDR = 20'h10000;
      tick();
      chk("oob_pulse", 16'(oob), 16'h1);
      bus.UB = 1'b1; bus.LB = 1'b1;
      tick();
      chk("oob_clear", 16'(oob), 16'h0);
      chk("oob_read_zero", data, 16'h0000);
      idle();
      wr_word(20'h10012, 16'h7777, 1'b0, 1'b0);
      rd_word("oob_write_dropped", 20'h00012, 1'b0, 1'b0, 16'hBEEF);
      chk("oob_wr_count", wr_count, 16'd9);
      chk("oob_rd_count", rd_count, 16'd12);
      bus.CE = 1'b0; bus.WE = 1'b1; bus.OE = 1'b0; bus.UB = 1'b0; bus.LB = 1'b0; bus.ADDR = 20'h00012;
      tick();
      bus.UB = 1'b1; bus.LB = 1'b1;
      tick();
      chk("pre_reset_read", data, 16'hBEEF);
      #2 Reset = 1'b0;
      #1;
      chk("async_reset_z", data, 16'hFFFF);
      chk("async_reset_rd_count", rd_count, 16'h0);
      chk("async_reset_init_done", 16'(init_done), 16'h0);
      idle();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
